// File: rtl/fixed_point_requantizer.sv
// Multi-lane fixed-point requantizer: 2-stage valid/ready pipe that
// re-scales signed Q-format lanes between exponents with saturation.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_valid_i/in_ready_o input beat handshake
//   in_data_i             Lanes x InWidth, lane k at [k*InWidth +: InWidth]
//   out_valid_o/out_ready_i output beat handshake
//   out_data_o            Lanes x OutWidth, lane k at [k*OutWidth +: OutWidth]
//   out_sat_o             per-lane clamp flags for the output beat
//   clear_count_i         zero the saturation counter (wins over increment)
//   sat_count_o           saturating count of clamped lanes
//
// Build option: define REQUANT_ROUND_NEAREST_EN to round half-up on the
// right-shift path; otherwise the right shift floors.
module fixed_point_requantizer #(
  parameter int Lanes         = 4,
  parameter int InWidth       = 8,
  parameter int InExp         = -3,
  parameter int OutWidth      = 9,
  parameter int OutExp        = 0,
  parameter int SatCountWidth = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [Lanes*InWidth-1:0]    in_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [Lanes*OutWidth-1:0]   out_data_o,
  output logic [Lanes-1:0]            out_sat_o,
  input  logic                        clear_count_i,
  output logic [SatCountWidth-1:0]    sat_count_o
);

  localparam int Shift    = OutExp - InExp;
  localparam int AbsShift = (Shift < 0) ? -Shift : Shift;
  localparam int Wi       = InWidth + OutWidth + AbsShift;
  localparam int PcW      = $clog2(Lanes + 1);

  localparam logic signed [Wi-1:0] MaxW =
    {{(Wi-OutWidth+1){1'b0}}, {(OutWidth-1){1'b1}}};
  localparam logic signed [Wi-1:0] MinW =
    {{(Wi-OutWidth+1){1'b1}}, {(OutWidth-1){1'b0}}};
  localparam logic [OutWidth-1:0] MaxO =
    {1'b0, {(OutWidth-1){1'b1}}};
  localparam logic [OutWidth-1:0] MinO =
    {1'b1, {(OutWidth-1){1'b0}}};

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  logic s2_load;

  logic [Lanes-1:0][Wi-1:0]       al_d;
  logic [Lanes-1:0][Wi-1:0]       s1_al;
  logic [Lanes-1:0][OutWidth-1:0] sat_data;
  logic [Lanes-1:0]               sat_flag;

  logic [PcW-1:0]             pc;
  logic [SatCountWidth:0]     cnt_sum;
  logic [SatCountWidth-1:0]   cnt_next;

  // A stage may take new data when it is empty or drains this cycle.
  assign s2_adv     = !s2_valid || out_ready_i;
  assign s1_adv     = !s1_valid || s2_adv;
  assign s2_load    = s2_adv && s1_valid;
  assign in_ready_o = s1_adv;
  assign out_valid_o = s2_valid;

  // Stage 1: sign-extend each lane to Wi and align the binary point.
  for (genvar k = 0; k < Lanes; k++) begin : g_align
    logic [InWidth-1:0]     raw;
    logic signed [Wi-1:0]   ext;

    assign raw = in_data_i[k*InWidth +: InWidth];
    assign ext = {{(Wi-InWidth){raw[InWidth-1]}}, raw};

    if (Shift < 0) begin : g_left
      assign al_d[k] = ext <<< AbsShift;
    end else if (Shift > 0) begin : g_right
`ifdef REQUANT_ROUND_NEAREST_EN
      localparam logic [Wi-1:0] One =
        {{(Wi-1){1'b0}}, 1'b1};
      localparam logic signed [Wi-1:0] Half =
        One << (AbsShift - 1);
      // Wi has headroom above InWidth, so the bias cannot overflow.
      assign al_d[k] = (ext + Half) >>> AbsShift;
`else
      assign al_d[k] = ext >>> AbsShift;
`endif
    end else begin : g_eq
      assign al_d[k] = ext;
    end
  end

  // Stage 2 input: clamp the aligned value into OutWidth.
  for (genvar k = 0; k < Lanes; k++) begin : g_sat
    logic signed [Wi-1:0] v;
    logic                 hi;
    logic                 lo;

    assign v  = s1_al[k];
    assign hi = v > MaxW;
    assign lo = v < MinW;

    assign sat_flag[k] = hi || lo;
    assign sat_data[k] = hi ? MaxO :
                         lo ? MinO :
                         v[OutWidth-1:0];
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < Lanes; i++) begin
      pc = pc + PcW'(sat_flag[i]);
    end
  end

  // One extra bit catches the carry so the counter pins at all-ones.
  assign cnt_sum  = {1'b0, sat_count_o}
                  + (SatCountWidth+1)'(pc);
  assign cnt_next = cnt_sum[SatCountWidth] ?
                    '1 : cnt_sum[SatCountWidth-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s1_al       <= '0;
      out_data_o  <= '0;
      out_sat_o   <= '0;
      sat_count_o <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid_i;
        if (in_valid_i) begin
          s1_al <= al_d;
        end
      end

      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data_o <= sat_data;
          out_sat_o  <= sat_flag;
        end
      end

      if (clear_count_i) begin
        sat_count_o <= '0;
      end else if (s2_load) begin
        sat_count_o <= cnt_next;
      end
    end
  end

endmodule
